// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage. It holds the PC register and
// the IF/ID pipeline register, applies hazard-unit stall/flush controls, and
// redirects the PC on branches and jumps resolved in ID.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/stall/flush
// performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        if_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instru,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instru_q, instru_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [XLEN-1:0] ipc4_q, ipc4_d;
  logic            valid_q, valid_d;

  logic            redirect_c;
  logic            flush_c;
  logic            fetch_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] pc_plus4_c;

  // Redirect selection; jump has priority and targets are word aligned.
  always_comb begin
    redirect_c = jump | branch_taken;
    target_c   = jump ? jump_target : branch_target;
    target_c   = {target_c[XLEN-1:2], 2'b00};
    pc_plus4_c = pc_q + XLEN'(4);
    flush_c    = if_flush | redirect_c;
  end

  // Next-state for PC and IF/ID register.
  always_comb begin
    pc_d     = pc_q;
    instru_d = instru_q;
    ipc_d    = ipc_q;
    ipc4_d   = ipc4_q;
    valid_d  = valid_q;
    fetch_c  = 1'b0;

    if (redirect_c) begin
      pc_d = target_c;
    end else if (pc_write && imem_ready) begin
      pc_d = pc_plus4_c;
    end

    if (flush_c) begin
      // Bubble; PC fields are kept for debug visibility only.
      instru_d = NOP_INSTR;
      valid_d  = 1'b0;
      ipc_d    = pc_q;
      ipc4_d   = pc_plus4_c;
    end else if (!ifid_write) begin
      instru_d = instru_q;
    end else if (!imem_ready) begin
      instru_d = NOP_INSTR;
      valid_d  = 1'b0;
    end else begin
      instru_d = imem_rdata;
      ipc_d    = pc_q;
      ipc4_d   = pc_plus4_c;
      valid_d  = 1'b1;
      fetch_c  = 1'b1;
    end
  end

  // PC and IF/ID state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instru_q <= NOP_INSTR;
      ipc_q    <= '0;
      ipc4_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instru_q <= instru_d;
      ipc_q    <= ipc_d;
      ipc4_q   <= ipc4_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ifid_instru = instru_q;
  assign ifid_pc     = ipc_q;
  assign ifid_pc4    = ipc4_q;
  assign ifid_valid  = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_c && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + XLEN'(1);
    end
    if (!ifid_write && !flush_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + XLEN'(1);
    end
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register. Consumes the hazard unit's stall/flush controls (PCWrite, IFIDWrite, IF flush) and the ID-stage branch/jump redirect. Drives the instruction-memory address. Presents instru/PC/PC+4/valid to the ID stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble instruction written into IF/ID on flush or fetch miss

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
pc_write  input  1  hazard unit PCWrite; 0 = hold PC
ifid_write  input  1  hazard unit IFIDWrite; 0 = hold IF/ID
if_flush  input  1  hazard unit IF flush; bubble into IF/ID
branch_taken  input  1  ID-stage branch resolved taken
branch_target  input  32  branch destination
jump  input  1  ID-stage j/jal
jump_target  input  32  jump destination
imem_addr  output  32  instruction memory address (= PC, combinational)
imem_rdata  input  32  instruction word at imem_addr
imem_ready  input  1  imem_rdata valid this cycle
ifid_instru  output  32  IF/ID.instru
ifid_pc  output  32  IF/ID.PC of held instruction
ifid_pc4  output  32  IF/ID.PC+4
ifid_valid  output  1  1 = IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC, ifid_instru=NOP_INSTR, ifid_pc=0, ifid_pc4=0, ifid_valid=0. Reset mid-stall or mid-redirect discards everything.
- redirect = jump | branch_taken; target = jump ? jump_target : branch_target (jump wins if both); target[1:0] forced to 2'b00.
- PC update priority per cycle:
  1. redirect: pc <= target, regardless of pc_write / imem_ready.
  2. pc_write & imem_ready: pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  3. otherwise hold.
- IF/ID update priority per cycle:
  1. if_flush | redirect: ifid_instru <= NOP_INSTR, ifid_valid <= 0, ifid_pc/ifid_pc4 <= pc/pc+4 (debug only). Flush overrides ifid_write=0.
  2. ifid_write=0: hold all IF/ID fields.
  3. imem_ready=0: bubble (NOP_INSTR, valid 0); PC holds so the same address is refetched.
  4. else: ifid_instru <= imem_rdata, ifid_pc <= pc, ifid_pc4 <= pc+4, ifid_valid <= 1.
- Latency: an instruction at address A appears on ifid_* one cycle after PC=A with imem_ready=1.
- Load-use stall (pc_write=0, ifid_write=0): PC and IF/ID frozen for exactly the stall cycles; no instruction lost or duplicated.
- Redirect during stall: redirect wins, stall ignored for PC; wrong-path instruction in IF is squashed.
- Inconsistent pc_write=1 with ifid_write=0 and no flush: PC advances, IF/ID holds (the in-flight fetch is dropped); this is legal but the hazard unit never issues it.
- All outputs are registered except imem_addr.

Optional Feature:
Macro IF_PERF_CNT_EN. When defined, three extra outputs are added, each 32 bits and saturating at 32'hFFFF_FFFF, all cleared on reset:
- perf_fetch_cnt: increments on every IF/ID load with valid=1.
- perf_stall_cnt: increments on every cycle with ifid_write=0 and no flush.
- perf_flush_cnt: increments on every cycle with if_flush or redirect.
When not defined, these ports and the counter logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, imem returns 32'h2000_0000+addr -> cycle 1: ifid_instru=32'h2000_0000, ifid_pc=0, ifid_pc4=4, valid=1; cycle 2: ifid_pc=4.
- Load-use stall: pc_write=ifid_write=0 for 1 cycle at pc=8 -> IF/ID keeps pc=4 for an extra cycle, then pc=8 is delivered once; no skipped or repeated address.
- Taken branch: branch_taken=1, branch_target=32'h40 at pc=12 -> next cycle ifid_valid=0 with NOP; following cycle ifid_pc=32'h40.
- Jump and branch together, targets 32'h100/32'h200, during a stall -> pc=32'h100, IF/ID flushed, stall ignored.
- imem_ready=0 for 3 cycles at pc=16 -> 3 bubbles (valid 0), pc stays 16; then instruction at 16 is delivered; target 32'h43 is taken as 32'h40.
- Wrap: pc=32'hFFFF_FFFC -> next pc=0. With IF_PERF_CNT_EN, after the first four scenarios the counters match the hand-counted fetch/stall/flush totals; reset mid-run clears them to 0.
